multiplier_nbit_seq: RTL
========================

// Module: multiplier_nbit_seq
// PURPOSE
//   Parametrised sequential shift-add multiplier with carry-in, signed/unsigned
//   mode and start/busy/done handshake. Integer ALU multiply unit; replaces the
//   fixed 4-bit combinational multiplier where WIDTH > 4 or area matters.
//   One operand bit is processed per clock. Result is held until the next accepted start.
// PARAMETERS
//   WIDTH     4                    operand width in bits; legal range >= 2
//   CNT_W     $clog2(WIDTH+1)      localparam; width of the iteration counter
// PORTS
//   clk          in   1        rising-edge clock
//   rst_n        in   1        asynchronous active-low reset
//   start        in   1        request; sampled only while busy=0
//   signed_mode  in   1        1: A,B two's complement; 0: unsigned. Captured with start
//   A            in   WIDTH    multiplicand, captured at the accepted start edge
//   B            in   WIDTH    multiplier, captured at the accepted start edge
//   carry_in     in   1        added as +1 to the product, captured with start
//   busy         out  1        high while an operation is in progress
//   done         out  1        single-cycle pulse: PRODUCT/carry_out just updated
//   PRODUCT      out  2*WIDTH  A*B + carry_in, modulo 2^(2*WIDTH)
//   carry_out    out  1        result does not fit in WIDTH bits (see below)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; busy=0, done=0, PRODUCT=0, carry_out=0,
//     counter=0. Takes effect immediately, including mid-operation, and aborts
//     the operation. No done is issued for an aborted operation.
//   FSM: IDLE -> CALC -> FINISH -> IDLE.
//   IDLE: at an edge with start=1, latch |A|, |B| (signed_mode: magnitude,
//     negate flag = A[MSB]^B[MSB]; unsigned: raw values, flag=0), carry_in;
//     clear accumulator, counter=0; busy<=1; go to CALC. With start=0: stay.
//   CALC: each edge: if mult LSB=1 add mcand to accumulator upper half, then
//     shift {acc,mult} right by 1 (acc is WIDTH+1 bits to keep the add carry).
//     After WIDTH edges (counter==WIDTH-1 on the last edge) go to FINISH.
//   FINISH edge: PRODUCT <= (neg ? -p : p) + carry_in (2*WIDTH-bit wrap);
//     carry_out <= unsigned: |PRODUCT[2W-1:W]; signed: PRODUCT[2W-1:W-1] not
//     all-equal (upper half is not the sign extension of the lower half);
//     done<=1 for exactly one cycle; busy<=0; go to IDLE.
//   Latency: start accepted at edge t0 -> PRODUCT/done valid after edge
//     t0+WIDTH+1; busy is high from t0 through t0+WIDTH+1 (WIDTH+1 cycles).
//   start while busy=1: ignored entirely; operands are not re-sampled.
//   start at the same edge on which FINISH completes: ignored (busy still 1).
//   start is accepted at the first edge after done is asserted (back-to-back
//     throughput = WIDTH+2 cycles).
//   PRODUCT and carry_out are stable between done pulses; A/B may change freely
//     while busy=1.
//   Signed edge case: most-negative * most-negative (-2^(W-1))^2 must be exact,
//     so magnitudes are held in WIDTH bits unsigned (2^(W-1) is representable).
//   No combinational input-to-output paths; all outputs are registered.
// TESTING (WIDTH=4)
//   unsigned A=2,B=1,ci=0 -> after 5 cycles done=1, PRODUCT=8'h02, carry_out=0
//   unsigned A=1,B=7,ci=1 -> PRODUCT=8'h08, carry_out=0; A=15,B=15,ci=1 ->
//     PRODUCT=8'hE2, carry_out=1
//   signed A=4'b1101(-3),B=4'b0101(5) -> PRODUCT=8'hF1(-15), carry_out=1;
//     A=B=4'b1000 -> PRODUCT=8'h40, carry_out=1; A=4'b1111,B=4'b0011,ci=1 ->
//     PRODUCT=8'hFE, carry_out=0
//   start pulsed again 2 cycles after an accepted start (A=3,B=3) with A=9,B=9
//     -> ignored; PRODUCT=8'h09 at the expected edge; exactly one done pulse
//   rst_n low during CALC -> busy/done/PRODUCT/carry_out go to 0 immediately;
//     no done follows; the next start completes normally
//   back-to-back: start held high continuously -> done pulses every 6 cycles,
//     busy never high in the same cycle as done

Source files
------------

// File: rtl/multiplier_nbit_seq.sv
// Sequential shift-add multiplier with carry-in and signed/unsigned modes.
// It processes one multiplier bit per clock. A start/busy/done handshake
// frames each operation. The product is A*B + carry_in, modulo 2^(2*WIDTH).
// The result registers hold their value until the next accepted start completes.
module multiplier_nbit_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 carry_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   PRODUCT,
    output logic                 carry_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]   counter;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mult;
    logic [WIDTH:0]     acc;
    logic               neg;
    logic               cin;
    logic               mode;

    logic               load;
    logic               step;
    logic               finish;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     acc_sum;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_signed;
    logic [2*WIDTH-1:0] prod_final;
    logic               overflow;

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start is only honoured in IDLE, so it is ignored while busy
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (counter == CNT_W'(WIDTH - 1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control decode driving the datapath enables
    always_comb begin
        load   = (state == IDLE) && start;
        step   = (state == CALC);
        finish = (state == FINISH);
    end

    // Operand magnitudes, the add step and the final sign/carry-in correction.
    // Magnitudes are WIDTH-bit unsigned values, which keeps 2^(WIDTH-1) exact.
    always_comb begin
        a_mag       = (signed_mode && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
        b_mag       = (signed_mode && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;
        acc_sum     = acc + (mult[0] ? {1'b0, mcand} : {(WIDTH + 1){1'b0}});
        prod_mag    = {acc[WIDTH-1:0], mult};
        prod_signed = neg ? (~prod_mag + (2*WIDTH)'(1)) : prod_mag;
        prod_final  = prod_signed + (2*WIDTH)'(cin);
        if (mode) begin
            overflow = !((&prod_final[2*WIDTH-1:WIDTH-1]) ||
                         (~|prod_final[2*WIDTH-1:WIDTH-1]));
        end else begin
            overflow = |prod_final[2*WIDTH-1:WIDTH];
        end
    end

    // Datapath and registered outputs: capture, shift-add iterations, result commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter   <= '0;
            mcand     <= '0;
            mult      <= '0;
            acc       <= '0;
            neg       <= 1'b0;
            cin       <= 1'b0;
            mode      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            PRODUCT   <= '0;
            carry_out <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= finish;
            if (load) begin
                mcand   <= a_mag;
                mult    <= b_mag;
                acc     <= '0;
                counter <= '0;
                neg     <= signed_mode && (A[WIDTH-1] ^ B[WIDTH-1]);
                cin     <= carry_in;
                mode    <= signed_mode;
            end else if (step) begin
                acc     <= {1'b0, acc_sum[WIDTH:1]};
                mult    <= {acc_sum[0], mult[WIDTH-1:1]};
                counter <= counter + CNT_W'(1);
            end else if (finish) begin
                PRODUCT   <= prod_final;
                carry_out <= overflow;
            end
        end
    end

endmodule
